// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and bounds for the serial pattern detector.
//   det_state_t : FSM encoding (S_FILL collects a full window, S_HUNT checks every bit)
//   PAT_W_MAX   : largest supported pattern length
//   CNT_W_MAX   : largest supported match counter width
package seq_det_pkg;

  typedef enum logic [0:0] {
    S_FILL,
    S_HUNT
  } det_state_t;

  localparam int unsigned PAT_W_MAX = 16;
  localparam int unsigned CNT_W_MAX = 16;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Interface bundling the detector's stream, control and status signals.
//   master : stream source / controller (drives en, din, overlap, pat_load, pattern_in, clr)
//   slave  : the detector (drives q, match_cnt, armed)
interface seq_pattern_detector_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  logic             din;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pattern_in;
  logic             clr;
  logic             q;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output en, din, overlap, pat_load, pattern_in, clr,
    input  q, match_cnt, armed
  );

  modport slave (
    input  en, din, overlap, pat_load, pattern_in, clr,
    output q, match_cnt, armed
  );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter used for the detector's match count.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once the count is all ones)
//   clr   : synchronous clear, has priority over inc
//   cnt   : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with programmable PAT_W-bit pattern.
//   CLK     : clock
//   reset_n : asynchronous active-low reset
//   bus     : slave modport of seq_pattern_detector_if
//             en/din stream, overlap mode, pat_load/pattern_in, clr,
//             q match flag, match_cnt saturating count, armed (window full)
// Build option SEQ_DET_REG_OUT_EN: when defined q is registered (one cycle
// after the completing bit); otherwise q is the combinational match.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  seq_pattern_detector_if.slave bus
);

  localparam int unsigned FCNT_W = $clog2(PAT_W);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(PAT_W - 1);

  if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_pat_w_err
    $error("seq_pattern_detector: PAT_W=%0d outside 2..%0d", PAT_W, PAT_W_MAX);
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_cnt_w_err
    $error("seq_pattern_detector: CNT_W=%0d outside 1..%0d", CNT_W, CNT_W_MAX);
  end

  det_state_t        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic              match;

  // Window is the stored history plus the bit arriving this cycle.
  assign window = {hist_q, bus.din};
  assign hit    = (window == pat_q);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    match   = 1'b0;
    if (bus.pat_load) begin
      // Loading a pattern flushes all progress; the din of this cycle is dropped.
      pat_d   = bus.pattern_in;
      hist_d  = '0;
      fcnt_d  = '0;
      state_d = S_FILL;
    end else if (bus.en) begin
      hist_d = window[PAT_W-2:0];
      unique case (state_q)
        S_FILL: begin
          if (fcnt_q == FCNT_LAST) begin
            match  = hit;
            fcnt_d = '0;
            // Non-overlapping hit restarts the fill; anything else arms hunting.
            if (!(hit && !bus.overlap)) begin
              state_d = S_HUNT;
            end
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        S_HUNT: begin
          match = hit;
          if (hit && !bus.overlap) begin
            state_d = S_FILL;
            fcnt_d  = '0;
          end
        end
        default: begin
          state_d = S_FILL;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FILL;
      fcnt_q  <= '0;
      hist_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
    end
  end

  assign bus.armed = (state_q == S_HUNT);

`ifdef SEQ_DET_REG_OUT_EN
  logic q_q;
  logic q_d;

  assign q_d = match;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q = q_q;
`else
  assign bus.q = match;
`endif

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (CLK),
    .rst_n (reset_n),
    .inc   (match),
    .clr   (bus.clr),
    .cnt   (bus.match_cnt)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

  logic clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  // Stimulus staging; sel picks DUT 0 (CNT_W=8) or DUT 1 (CNT_W=2).
  bit         sel_s;
  logic       en_s, din_s, ld_s, clr_s, ov_s;
  logic [3:0] pat_s;

  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) if0 ();
  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(2)) if1 ();

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8)) u_dut0 (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (if0)
  );

  seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) u_dut1 (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    if (sel_s == 1'b0) begin
      if0.en = en_s; if0.din = din_s; if0.pat_load = ld_s; if0.clr = clr_s;
      if0.overlap = ov_s; if0.pattern_in = pat_s;
      if1.en = 1'b0; if1.pat_load = 1'b0; if1.clr = 1'b0;
    end else begin
      if1.en = en_s; if1.din = din_s; if1.pat_load = ld_s; if1.clr = clr_s;
      if1.overlap = ov_s; if1.pattern_in = pat_s;
      if0.en = 1'b0; if0.pat_load = 1'b0; if0.clr = 1'b0;
    end
  endtask

  function automatic logic q_of();
    return (sel_s == 1'b0) ? if0.q : if1.q;
  endfunction

  function automatic logic [31:0] cnt_of();
    return (sel_s == 1'b0) ? 32'(if0.match_cnt) : 32'(if1.match_cnt);
  endfunction

  function automatic logic armed_of();
    return (sel_s == 1'b0) ? if0.armed : if1.armed;
  endfunction

  // One clock: drive at negedge, check Mealy q before the edge,
  // registered q / count / armed just after the edge.
  task automatic cyc(input string tag, input logic exp_m, input int exp_cnt, input logic exp_armed);
    @(negedge clk);
    apply();
    #1;
`ifndef SEQ_DET_REG_OUT_EN
    chk({tag, ".q"}, 32'(q_of()), 32'(exp_m));
`endif
    @(posedge clk);
    #1;
`ifdef SEQ_DET_REG_OUT_EN
    chk({tag, ".q"}, 32'(q_of()), 32'(exp_m));
`endif
    chk({tag, ".cnt"}, cnt_of(), 32'(exp_cnt));
    chk({tag, ".armed"}, 32'(armed_of()), 32'(exp_armed));
  endtask

  task automatic bit_in(input string tag, input logic d, input logic exp_m,
                        input int exp_cnt, input logic exp_armed);
    en_s = 1'b1; din_s = d; ld_s = 1'b0; clr_s = 1'b0;
    cyc(tag, exp_m, exp_cnt, exp_armed);
  endtask

  task automatic idle(input string tag, input logic d, input int exp_cnt, input logic exp_armed);
    en_s = 1'b0; din_s = d; ld_s = 1'b0; clr_s = 1'b0;
    cyc(tag, 1'b0, exp_cnt, exp_armed);
  endtask

  task automatic load(input string tag, input logic [3:0] p, input logic c, input logic d,
                      input int exp_cnt);
    en_s = 1'b1; din_s = d; ld_s = 1'b1; clr_s = c; pat_s = p;
    cyc(tag, 1'b0, exp_cnt, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    sel_s = 1'b0; en_s = 1'b0; din_s = 1'b0; ld_s = 1'b0; clr_s = 1'b0;
    ov_s = 1'b1; pat_s = 4'b0000;
    if0.en = 1'b0; if0.din = 1'b0; if0.overlap = 1'b1; if0.pat_load = 1'b0;
    if0.pattern_in = '0; if0.clr = 1'b0;
    if1.en = 1'b0; if1.din = 1'b0; if1.overlap = 1'b1; if1.pat_load = 1'b0;
    if1.pattern_in = '0; if1.clr = 1'b0;
    #12;
    chk("rst.q0", 32'(if0.q), 32'd0);
    chk("rst.cnt0", 32'(if0.match_cnt), 32'd0);
    chk("rst.armed0", 32'(if0.armed), 32'd0);
    chk("rst.cnt1", 32'(if1.match_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Pattern 1101, overlapping: hits on bits 4 and 7.
    sel_s = 1'b0; ov_s = 1'b1;
    load("t2.ld", 4'b1101, 1'b0, 1'b0, 0);
    bit_in("t2.b1", 1'b1, 1'b0, 0, 1'b0);
    bit_in("t2.b2", 1'b1, 1'b0, 0, 1'b0);
    bit_in("t2.b3", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t2.b4", 1'b1, 1'b1, 1, 1'b1);
    bit_in("t2.b5", 1'b1, 1'b0, 1, 1'b1);
    bit_in("t2.b6", 1'b0, 1'b0, 1, 1'b1);
    bit_in("t2.b7", 1'b1, 1'b1, 2, 1'b1);

    // Same stream non-overlapping, count cleared alongside the reload.
    ov_s = 1'b0;
    load("t3.ld", 4'b1101, 1'b1, 1'b0, 0);
    bit_in("t3.b1", 1'b1, 1'b0, 0, 1'b0);
    bit_in("t3.b2", 1'b1, 1'b0, 0, 1'b0);
    bit_in("t3.b3", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t3.b4", 1'b1, 1'b1, 1, 1'b0);
    bit_in("t3.b5", 1'b1, 1'b0, 1, 1'b0);
    bit_in("t3.b6", 1'b0, 1'b0, 1, 1'b0);
    bit_in("t3.b7", 1'b1, 1'b0, 1, 1'b0);

    // Pattern 1111 with en toggling; din=0 on invalid cycles must be ignored.
    ov_s = 1'b1;
    load("t4.ld", 4'b1111, 1'b1, 1'b0, 0);
    bit_in("t4.v1", 1'b1, 1'b0, 0, 1'b0);
    idle("t4.x1", 1'b0, 0, 1'b0);
    bit_in("t4.v2", 1'b1, 1'b0, 0, 1'b0);
    idle("t4.x2", 1'b0, 0, 1'b0);
    bit_in("t4.v3", 1'b1, 1'b0, 0, 1'b0);
    idle("t4.x3", 1'b0, 0, 1'b0);
    bit_in("t4.v4", 1'b1, 1'b1, 1, 1'b1);
    idle("t4.x4", 1'b0, 1, 1'b1);
    bit_in("t4.v5", 1'b1, 1'b1, 2, 1'b1);
    idle("t4.x5", 1'b1, 2, 1'b1);
    bit_in("t4.v6", 1'b1, 1'b1, 3, 1'b1);
    idle("t4.x6", 1'b0, 3, 1'b1);
    bit_in("t4.v7", 1'b1, 1'b1, 4, 1'b1);

    // Reload 1010 on what would complete 1111: no match, count kept.
    load("t6.ld", 4'b1010, 1'b0, 1'b1, 4);
    bit_in("t6.b1", 1'b1, 1'b0, 4, 1'b0);
    bit_in("t6.b2", 1'b0, 1'b0, 4, 1'b0);
    bit_in("t6.b3", 1'b1, 1'b0, 4, 1'b0);
    bit_in("t6.b4", 1'b0, 1'b1, 5, 1'b1);
    bit_in("t6.b5", 1'b1, 1'b0, 5, 1'b1);

    // Asynchronous reset mid-stream; pattern returns to 0000.
    @(negedge clk);
    if0.en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t1.q", 32'(if0.q), 32'd0);
    chk("t1.cnt", 32'(if0.match_cnt), 32'd0);
    chk("t1.armed", 32'(if0.armed), 32'd0);
    #2;
    reset_n = 1'b1;
    bit_in("t1.b1", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t1.b2", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t1.b3", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t1.b4", 1'b0, 1'b1, 1, 1'b1);

    // CNT_W=2 instance: saturation at 3, then clr beats a match.
    sel_s = 1'b1; ov_s = 1'b1;
    load("t5.ld", 4'b0000, 1'b0, 1'b0, 0);
    bit_in("t5.b1", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t5.b2", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t5.b3", 1'b0, 1'b0, 0, 1'b0);
    bit_in("t5.b4", 1'b0, 1'b1, 1, 1'b1);
    bit_in("t5.b5", 1'b0, 1'b1, 2, 1'b1);
    bit_in("t5.b6", 1'b0, 1'b1, 3, 1'b1);
    bit_in("t5.b7", 1'b0, 1'b1, 3, 1'b1);
    bit_in("t5.b8", 1'b0, 1'b1, 3, 1'b1);
    bit_in("t5.b9", 1'b0, 1'b1, 3, 1'b1);
    en_s = 1'b1; din_s = 1'b0; ld_s = 1'b0; clr_s = 1'b1;
    cyc("t5.clr", 1'b1, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
